// File: rtl/shift_unit_if.sv
// rtl/shift_unit_if.sv - command/status bundle for the universal shift register
interface shift_unit_if #(
   parameter int WIDTH = 8
);
   localparam int AW = $clog2(WIDTH);

   logic             en;
   logic [2:0]       mode;
   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] d;
   logic             sin;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, amt, d, sin,
      input  q, sout, busy, done
   );

   modport slave (
      input  en, mode, amt, d, sin,
      output q, sout, busy, done
   );
endinterface

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - parametrised universal shift register with serial-shift mode
module shift_unit #(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst,
   shift_unit_if.slave bus
);
   localparam int AW = $clog2(WIDTH);

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_LOAD = 3'd1;
   localparam logic [2:0] MODE_SLL  = 3'd2;
   localparam logic [2:0] MODE_SRL  = 3'd3;
   localparam logic [2:0] MODE_SRA  = 3'd4;
   localparam logic [2:0] MODE_ROL  = 3'd5;
   localparam logic [2:0] MODE_ROR  = 3'd6;
   localparam logic [2:0] MODE_SER  = 3'd7;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [WIDTH-1:0]   q_r;
   logic               sout_r;
   logic               done_r;
   logic [0:0]         state;
   logic [AW-1:0]      count;

   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] rol_wide;
   logic [2*WIDTH-1:0] ror_wide;
   logic [WIDTH-1:0]   sll_v;
   logic [WIDTH-1:0]   srl_v;
   logic [WIDTH-1:0]   sra_v;
   logic [WIDTH-1:0]   rol_v;
   logic [WIDTH-1:0]   ror_v;
   logic [WIDTH-1:0]   next_q;

   // Rotates read a window out of q concatenated with itself; amt=0 selects q unchanged.
   always_comb begin
      dbl      = {q_r, q_r};
      rol_wide = dbl >> (WIDTH - int'(bus.amt));
      ror_wide = dbl >> bus.amt;
      sll_v    = q_r << bus.amt;
      srl_v    = q_r >> bus.amt;
      sra_v    = $signed(q_r) >>> bus.amt;
      rol_v    = rol_wide[WIDTH-1:0];
      ror_v    = ror_wide[WIDTH-1:0];
   end

   always_comb begin
      next_q = q_r;
      case (bus.mode)
         MODE_HOLD: next_q = q_r;
         MODE_LOAD: next_q = bus.d;
         MODE_SLL:  next_q = sll_v;
         MODE_SRL:  next_q = srl_v;
         MODE_SRA:  next_q = sra_v;
         MODE_ROL:  next_q = rol_v;
         MODE_ROR:  next_q = ror_v;
         default:   next_q = q_r;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r    <= '0;
         sout_r <= 1'b0;
         done_r <= 1'b0;
         state  <= ST_IDLE;
         count  <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.en) begin
                  if (bus.mode == MODE_SER) begin
                     if (bus.amt != '0) begin
                        count <= bus.amt;
                        state <= ST_SHIFT;
                     end else begin
                        done_r <= 1'b1;
                     end
                  end else begin
                     q_r <= next_q;
                  end
               end
            end
            ST_SHIFT: begin
               // Inputs other than sin are ignored; a busy-time command is dropped.
               q_r    <= {q_r[WIDTH-2:0], bus.sin};
               sout_r <= q_r[WIDTH-1];
               count  <= count - AW'(1);
               if (count == AW'(1)) begin
                  state  <= ST_IDLE;
                  done_r <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.q    = q_r;
   assign bus.sout = sout_r;
   assign bus.busy = (state == ST_SHIFT);
   assign bus.done = done_r;
endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - scoreboard bench for shift_unit against a behavioural model
module tb_shift_unit;
   localparam int WIDTH = 8;
   localparam int MASK  = (1 << WIDTH) - 1;

   typedef struct {
      int q;
      bit sout;
      bit busy;
      bit done;
   } exp_t;

   typedef struct {
      int q;
      bit sout;
   } ser_t;

   logic clk;
   logic rst;

   shift_unit_if #(.WIDTH(WIDTH)) bus ();

   shift_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   ser_t ser_q[$];
   bit   sin_q[$];
   int   mq;
   bit   msout;
   int   rem;
   bit   prev_rst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, predict the result of the next rising edge.
   task automatic cycle(input bit r, input bit e, input int m, input int a, input int dd);
      exp_t x;
      bit   b;
      b = 1'($urandom_range(0, 1));
      if (!r && rem > 0 && sin_q.size() > 0) b = sin_q.pop_front();
      rst      = r;
      bus.en   = e;
      bus.mode = 3'(m);
      bus.amt  = 3'(a);
      bus.d    = 8'(dd);
      bus.sin  = b;
      x.done   = 1'b0;
      if (r) begin
         if (!prev_rst) begin
            #1;
            chk("async_rst_q", 32'(bus.q), 0);
            chk("async_rst_sout", 32'(bus.sout), 0);
            chk("async_rst_busy", 32'(bus.busy), 0);
            chk("async_rst_done", 32'(bus.done), 0);
         end
         mq = 0;
         msout = 1'b0;
         rem = 0;
         sin_q.delete();
         ser_q.delete();
      end else if (rem > 0) begin
         msout = bit'((mq >> (WIDTH - 1)) & 1);
         mq    = ((mq << 1) | int'(b)) & MASK;
         rem--;
         x.done = (rem == 0);
      end else if (e) begin
         case (m)
            1: mq = dd & MASK;
            2: mq = (mq << a) & MASK;
            3: mq = mq >> a;
            4: repeat (a) mq = (mq >> 1) | (mq & (1 << (WIDTH - 1)));
            5: repeat (a) mq = ((mq << 1) | (mq >> (WIDTH - 1))) & MASK;
            6: repeat (a) mq = (mq >> 1) | ((mq & 1) << (WIDTH - 1));
            7: begin
               ser_t s;
               s.q    = mq;
               s.sout = msout;
               while (sin_q.size() < a) sin_q.push_back(1'($urandom_range(0, 1)));
               for (int i = 0; i < a; i++) begin
                  s.sout = bit'((s.q >> (WIDTH - 1)) & 1);
                  s.q    = ((s.q << 1) | int'(sin_q[i])) & MASK;
               end
               ser_q.push_back(s);
               if (a == 0) x.done = 1'b1;
               rem = a;
            end
            default: ;
         endcase
      end
      x.q    = mq;
      x.sout = msout;
      x.busy = (rem > 0);
      exp_q.push_back(x);
      prev_rst = r;
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t x;
      ser_t s;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk("q", 32'(bus.q), 32'(x.q));
         chk("sout", 32'(bus.sout), 32'(x.sout));
         chk("busy", 32'(bus.busy), 32'(x.busy));
         chk("done", 32'(bus.done), 32'(x.done));
      end
      if (bus.done === 1'b1) begin
         if (ser_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
         end else begin
            s = ser_q.pop_front();
            chk("ser_final_q", 32'(bus.q), 32'(s.q));
            chk("ser_final_sout", 32'(bus.sout), 32'(s.sout));
         end
      end
   end

   initial begin
      mq = 0;
      msout = 1'b0;
      rem = 0;
      prev_rst = 1'b1;
      rst = 1'b1;
      bus.en = 1'b0;
      bus.mode = 3'd0;
      bus.amt = 3'd0;
      bus.d = 8'd0;
      bus.sin = 1'b0;
      @(negedge clk);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 8'h5A);
      cycle(1, 1, 1, 0, 8'h33);
      cycle(0, 1, 1, 0, 8'hA5);
      chk("load_a5", 32'(bus.q), 32'h A5);
      cycle(0, 1, 2, 3, 0);
      chk("sll3", 32'(bus.q), 32'h28);
      cycle(0, 1, 1, 0, 8'h96);
      cycle(0, 1, 4, 2, 0);
      chk("sra2", 32'(bus.q), 32'hE5);
      cycle(0, 1, 1, 0, 8'h96);
      cycle(0, 1, 3, 2, 0);
      chk("srl2", 32'(bus.q), 32'h25);
      cycle(0, 1, 1, 0, 8'h81);
      cycle(0, 1, 6, 1, 0);
      chk("ror1", 32'(bus.q), 32'hC0);
      cycle(0, 1, 5, 1, 0);
      chk("rol1", 32'(bus.q), 32'h81);
      for (int m = 2; m <= 6; m++) cycle(0, 1, m, 0, 8'hFF);
      chk("amt0_unchanged", 32'(bus.q), 32'h81);

      cycle(0, 1, 1, 0, 8'h3C);
      sin_q.push_back(1'b1);
      sin_q.push_back(1'b0);
      sin_q.push_back(1'b1);
      sin_q.push_back(1'b1);
      cycle(0, 1, 7, 4, 0);
      chk("ser_busy_start", 32'(bus.busy), 1);
      chk("ser_q_untouched", 32'(bus.q), 32'h3C);
      repeat (4) cycle(0, 1, 1, 0, 8'hFF);
      chk("ser_result", 32'(bus.q), 32'hCB);
      chk("ser_done_pulse", 32'(bus.done), 1);
      cycle(0, 1, 1, 0, 8'h5A);
      chk("cmd_in_done_cycle", 32'(bus.q), 32'h5A);
      cycle(0, 1, 7, 0, 0);
      chk("ser0_done", 32'(bus.done), 1);
      chk("ser0_busy", 32'(bus.busy), 0);
      chk("ser0_q", 32'(bus.q), 32'h5A);

      cycle(0, 1, 7, 5, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      repeat (8) cycle(0, 0, 0, 0, 0);

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 7)), int'($urandom_range(0, WIDTH - 1)),
               int'($urandom_range(0, MASK)));
      end
      repeat (3) cycle(0, 0, 0, 0, 0);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
